gecko_run_monitor: RTL

Sits directly downstream of the gecko_micro core in simulation and FPGA test builds. It consumes the core's faulted/finished flags and drives the core's reset. It sequences a run: hold reset, release, count cycles, and detect pass, fault or watchdog timeout. It then emits a 5-byte result record on a valid/ready byte stream for a UART or testbench sink.

---
 rtl/gecko_run_monitor_pkg.sv | 44 ++++
 rtl/gecko_run_monitor_if.sv | 19 +
 rtl/gecko_record_serializer.sv | 52 +++++
 rtl/gecko_run_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gecko_run_monitor_pkg.sv
// Shared types and constants for the gecko run monitor: run result,
// FSM state encoding (visible to benches), status byte codes and the
// layout of the 5-byte result record.
package gecko_run_monitor_pkg;

    typedef enum logic [1:0] {
        GECKO_RUN_PASS    = 2'd0,
        GECKO_RUN_FAULT   = 2'd1,
        GECKO_RUN_TIMEOUT = 2'd2
    } gecko_run_result_t;

    typedef enum logic [2:0] {
        GECKO_ST_IDLE   = 3'd0,
        GECKO_ST_HOLD   = 3'd1,
        GECKO_ST_RUN    = 3'd2,
        GECKO_ST_REPORT = 3'd3,
        GECKO_ST_DONE   = 3'd4
    } gecko_run_state_t;

    localparam logic [7:0] GECKO_STATUS_PASS    = 8'h50;
    localparam logic [7:0] GECKO_STATUS_FAULT   = 8'h46;
    localparam logic [7:0] GECKO_STATUS_TIMEOUT = 8'h54;

    localparam int GECKO_RECORD_BYTES = 5;

    // Record as sent on the byte stream: status goes out first (lowest byte),
    // followed by the cycle count least-significant byte first.
    typedef struct packed {
        logic [31:0] count;
        logic [7:0]  status;
    } gecko_record_t;

    function automatic logic [7:0] gecko_status_code(input gecko_run_result_t result);
        logic [7:0] code;
        case (result)
            GECKO_RUN_PASS:    code = GECKO_STATUS_PASS;
            GECKO_RUN_FAULT:   code = GECKO_STATUS_FAULT;
            GECKO_RUN_TIMEOUT: code = GECKO_STATUS_TIMEOUT;
            default:           code = GECKO_STATUS_FAULT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gecko_run_monitor_if.sv
// Valid/ready byte stream carrying the run result record to a UART or
// bench sink. The monitor is the master; the sink drives ready.
interface gecko_run_monitor_if;
    logic       report_valid;
    logic       report_ready;
    logic [7:0] report_data;

    modport master (
        output report_valid,
        output report_data,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_data,
        output report_ready
    );
endinterface

// File: rtl/gecko_record_serializer.sv
// Loads a 40-bit record and shifts it out one byte per handshake,
// lowest byte first. Valid rises on the edge that loads the record so
// the first byte is offered with no bubble; data only moves on an
// accepted handshake, so it is stable while the sink stalls.
module gecko_record_serializer
    import gecko_run_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [39:0] i_record,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_last_accept
);

    localparam logic [2:0] LAST_IDX = 3'(GECKO_RECORD_BYTES - 1);

    logic [39:0] r_shift;
    logic [2:0]  r_idx;
    logic        r_valid;
    logic        w_accept;

    assign w_accept = r_valid && i_ready;

    // Record load, byte shift on each accepted handshake, valid drop after the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 40'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_record;
            r_idx   <= 3'd0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            if (r_idx == LAST_IDX) begin
                r_idx   <= 3'd0;
                r_valid <= 1'b0;
            end else begin
                r_shift <= {8'd0, r_shift[39:8]};
                r_idx   <= r_idx + 3'd1;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_shift[7:0];
    assign o_last_accept = w_accept && (r_idx == LAST_IDX);

endmodule

// File: rtl/gecko_run_monitor.sv
// Run sequencer for the gecko_micro core: holds the core in reset after
// start, releases it, counts run cycles, detects fault / pass / watchdog
// timeout and streams a 5-byte result record. Core flags come straight
// from registered outputs of the core, so the flag value seen in a RUN
// cycle is judged in that same cycle and the reported count includes it.
module gecko_run_monitor
    import gecko_run_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 1000000,
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter int unsigned COUNTER_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    output logic                     o_core_rst,
    input  logic                     i_faulted,
    input  logic                     i_finished,
    output logic                     o_done,
    output logic                     o_passed,
    output logic [COUNTER_WIDTH-1:0] o_cycle_count,
    gecko_run_monitor_if.master      report
);

    // A hold of 0 is treated as 1 so the core always sees at least one reset cycle.
    localparam logic [31:0] HOLD_LAST =
        (RESET_HOLD_CYCLES > 32'd1) ? 32'(RESET_HOLD_CYCLES - 32'd1) : 32'd0;
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_TO  = COUNTER_WIDTH'(TIMEOUT_CYCLES);

    gecko_run_state_t           r_state;
    gecko_run_state_t           w_state_next;
    gecko_run_result_t          r_result;
    gecko_run_result_t          w_result_next;
    logic [COUNTER_WIDTH-1:0]   r_count;
    logic [COUNTER_WIDTH-1:0]   w_count_inc;
    logic [31:0]                r_hold_cnt;
    logic                       r_core_rst;
    logic                       r_done;
    logic                       r_passed;
    logic                       w_timeout_hit;
    logic                       w_result_hit;
    logic                       w_load_record;
    logic                       w_ser_last_accept;
    gecko_record_t              w_record;

    // Saturating post-increment value; the count never wraps.
    assign w_count_inc   = (r_count == COUNT_MAX) ? r_count : (r_count + COUNT_ONE);
    assign w_timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (w_count_inc == COUNT_TO);

    // The record carries the count as it will be after the deciding cycle.
    assign w_record.count  = w_count_inc[31:0];
    assign w_record.status = gecko_status_code(w_result_next);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GECKO_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, result priority (fault over pass over timeout) and record load
    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_result_hit  = 1'b0;
        w_load_record = 1'b0;
        case (r_state)
            GECKO_ST_IDLE: begin
                if (i_start) begin
                    w_state_next = GECKO_ST_HOLD;
                end else begin
                    w_state_next = GECKO_ST_IDLE;
                end
            end
            GECKO_ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = GECKO_ST_RUN;
                end else begin
                    w_state_next = GECKO_ST_HOLD;
                end
            end
            GECKO_ST_RUN: begin
                if (i_faulted) begin
                    w_result_hit  = 1'b1;
                    w_result_next = GECKO_RUN_FAULT;
                end else if (i_finished) begin
                    w_result_hit  = 1'b1;
                    w_result_next = GECKO_RUN_PASS;
                end else if (w_timeout_hit) begin
                    w_result_hit  = 1'b1;
                    w_result_next = GECKO_RUN_TIMEOUT;
                end else begin
                    w_result_hit  = 1'b0;
                end
                if (w_result_hit) begin
                    w_state_next  = GECKO_ST_REPORT;
                    w_load_record = 1'b1;
                end else begin
                    w_state_next  = GECKO_ST_RUN;
                end
            end
            GECKO_ST_REPORT: begin
                if (w_ser_last_accept) begin
                    w_state_next = GECKO_ST_DONE;
                end else begin
                    w_state_next = GECKO_ST_REPORT;
                end
            end
            GECKO_ST_DONE: begin
                if (i_start) begin
                    w_state_next = GECKO_ST_HOLD;
                end else begin
                    w_state_next = GECKO_ST_DONE;
                end
            end
            default: begin
                w_state_next = GECKO_ST_IDLE;
            end
        endcase
    end

    // Run cycle counter: cleared when a run is started, advanced in RUN, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_state_next == GECKO_ST_HOLD &&
                     (r_state == GECKO_ST_IDLE || r_state == GECKO_ST_DONE)) begin
            r_count <= '0;
        end else if (r_state == GECKO_ST_RUN) begin
            r_count <= w_count_inc;
        end
    end

    // Reset-hold counter: counts cycles spent in HOLD, zero elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 32'd0;
        end else if (r_state == GECKO_ST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
        end else begin
            r_hold_cnt <= 32'd0;
        end
    end

    // Result latch, captured on the cycle the run ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= GECKO_RUN_PASS;
        end else if (w_load_record) begin
            r_result <= w_result_next;
        end
    end

    // Registered status outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_passed   <= 1'b0;
        end else begin
            r_core_rst <= (w_state_next != GECKO_ST_RUN);
            r_done     <= (w_state_next == GECKO_ST_DONE);
            r_passed   <= (w_state_next == GECKO_ST_DONE) && (r_result == GECKO_RUN_PASS);
        end
    end

    gecko_record_serializer u_serializer (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load_record),
        .i_record      (w_record),
        .i_ready       (report.report_ready),
        .o_valid       (report.report_valid),
        .o_data        (report.report_data),
        .o_last_accept (w_ser_last_accept)
    );

    assign o_core_rst    = r_core_rst;
    assign o_done        = r_done;
    assign o_passed      = r_passed;
    assign o_cycle_count = r_count;

endmodule
